wb_port_arbiter: RTL and testbench

- Shares the single general-register write port among NREQ writeback sources, e.g. ALU, LSU load return and CSR read.
- Each source gets a 1-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains one slot per cycle into a registered write port (O_rd_we/O_rd_waddr/O_rd_wdata) that feeds the register file directly.
- A busy mask exports pending destinations so the issue stage can hold dependent reads.

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: NREQ one-entry slots drained round-robin into a registered
// register-file write port. Optional WBARB_STALL_CNT_EN adds per-requester stall counters.
module wb_port_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      I_req_valid,
    output logic [NREQ-1:0]      O_req_ready,
    input  logic [NREQ*AW-1:0]   I_req_addr,
    input  logic [NREQ*DW-1:0]   I_req_data,
    output logic                 O_rd_we,
    output logic [AW-1:0]        O_rd_waddr,
    output logic [DW-1:0]        O_rd_wdata,
    output logic [(1<<AW)-1:0]   O_busy_mask
`ifdef WBARB_STALL_CNT_EN
    ,
    output logic [NREQ*32-1:0]   O_stall_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] slot_vld_p0;
    logic [AW-1:0]   slot_addr_p0 [NREQ];
    logic [DW-1:0]   slot_data_p0 [NREQ];
    logic [PW-1:0]   ptr;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] load;

    logic            rd_we_p1;
    logic [AW-1:0]   rd_waddr_p1;
    logic [DW-1:0]   rd_wdata_p1;

    // Index base+off reduced modulo NREQ; both operands are below NREQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NREQ)) begin
            sum = sum - 32'(NREQ);
        end
        return sum[PW-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // A draining slot may refill on the same edge.
    assign O_req_ready = ~slot_vld_p0 | grant;

    always_comb begin
        accept = '0;
        load   = '0;
        for (int i = 0; i < NREQ; i++) begin
            accept[i] = I_req_valid[i] && O_req_ready[i];
            load[i]   = accept[i] && (I_req_addr[i*AW +: AW] != '0);
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && slot_vld_p0[wrap_idx(ptr, 32'(k))]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(ptr, 32'(k));
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // ---- stage p0: holding slots and round-robin pointer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_p0 <= '0;
            ptr         <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (load[i]) begin
                    slot_vld_p0[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_vld_p0[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                ptr <= wrap_idx(grant_idx, 32'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (load[i]) begin
                slot_addr_p0[i] <= I_req_addr[i*AW +: AW];
                slot_data_p0[i] <= I_req_data[i*DW +: DW];
            end
        end
    end

    // ---- stage p1: registered register-file write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_we_p1    <= 1'b0;
            rd_waddr_p1 <= '0;
            rd_wdata_p1 <= '0;
        end else begin
            rd_we_p1 <= grant_any;
            if (grant_any) begin
                rd_waddr_p1 <= slot_addr_p0[grant_idx];
                rd_wdata_p1 <= slot_data_p0[grant_idx];
            end
        end
    end

    assign O_rd_we    = rd_we_p1;
    assign O_rd_waddr = rd_waddr_p1;
    assign O_rd_wdata = rd_wdata_p1;

    always_comb begin
        O_busy_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (slot_vld_p0[i]) begin
                O_busy_mask[slot_addr_p0[i]] = 1'b1;
            end
        end
        if (rd_we_p1) begin
            O_busy_mask[rd_waddr_p1] = 1'b1;
        end
    end

`ifdef WBARB_STALL_CNT_EN
    logic [31:0] stall_cnt [NREQ];

    // A stall is a cycle where the slot holds data but another requester won.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                stall_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (slot_vld_p0[i] && !grant[i]) begin
                    stall_cnt[i] <= sat_inc(stall_cnt[i]);
                end
            end
        end
    end

    always_comb begin
        O_stall_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            O_stall_cnt[i*32 +: 32] = stall_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every O_rd_we pulse.
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef logic [AW+DW-1:0] wr_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 rd_we;
    logic [AW-1:0]        rd_waddr;
    logic [DW-1:0]        rd_wdata;
    logic [(1<<AW)-1:0]   busy_mask;
`ifdef WBARB_STALL_CNT_EN
    logic [NREQ*32-1:0]   stall_cnt;
`endif

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t exp_q[$];

    wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .I_req_valid (req_valid),
        .O_req_ready (req_ready),
        .I_req_addr  (req_addr),
        .I_req_data  (req_data),
        .O_rd_we     (rd_we),
        .O_rd_waddr  (rd_waddr),
        .O_rd_wdata  (rd_wdata),
        .O_busy_mask (busy_mask)
`ifdef WBARB_STALL_CNT_EN
        ,
        .O_stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rd_waddr, rd_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_write", 64'({rd_waddr, rd_wdata}), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [NREQ-1:0] rr_pat [3];

    initial begin
        rr_pat[0] = 3'b001;
        rr_pat[1] = 3'b010;
        rr_pat[2] = 3'b100;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state
        do_reset();
        check("reset_we",    64'(rd_we),     64'd0);
        check("reset_waddr", 64'(rd_waddr),  64'd0);
        check("reset_wdata", 64'(rd_wdata),  64'd0);
        check("reset_busy",  64'(busy_mask), 64'd0);
        check("reset_ready", 64'(req_ready), 64'b111);

        // Single write
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        push_exp(5'd5, 32'hDEAD_BEEF);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        check("single_busy_c1", 64'(busy_mask), 64'h20);
        check("single_we_c1",   64'(rd_we),     64'd0);
        step();
        check("single_busy_c2", 64'(busy_mask), 64'h20);
        check("single_we_c2",   64'(rd_we),     64'd1);
        step();
        check("single_busy_c3", 64'(busy_mask), 64'h0);
        check("single_we_c3",   64'(rd_we),     64'd0);

        // Round-robin fairness, all three held valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, AW'(i + 1), 32'hA000_0000 + 32'(i));
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_exp(AW'(i + 1), 32'hA000_0000 + 32'(i));
            end
        end
        check("rr_ready_c0", 64'(req_ready), 64'b111);
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(rr_pat[(c - 1) % 3]));
        end
        step();
        req_valid = '0;
        repeat (4) step();
        check("rr_idle_busy", 64'(busy_mask), 64'h0);

        // x0 drop
        do_reset();
        set_req(1, 1'b1, 5'd0, 32'd123);
        check("x0_ready", 64'(req_ready[1]), 64'd1);
        step();
        set_req(1, 1'b0, 5'd0, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("x0_we_c%0d", c),   64'(rd_we),     64'd0);
            check($sformatf("x0_busy_c%0d", c), 64'(busy_mask), 64'h0);
            step();
        end

        // Back-to-back refill on requester 2
        do_reset();
        set_req(2, 1'b1, 5'd7, 32'h0000_0007);
        push_exp(5'd7, 32'h0000_0007);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k >= 2) begin
                check($sformatf("b2b_we_c%0d", k),    64'(rd_we),    64'd1);
                check($sformatf("b2b_waddr_c%0d", k), 64'(rd_waddr), 64'(5 + k));
            end
            if (k == 2) begin
                check("b2b_busy_c2", 64'(busy_mask), 64'h180);
            end
            if (k <= 3) begin
                check($sformatf("b2b_ready_c%0d", k), 64'(req_ready[2]), 64'd1);
                set_req(2, 1'b1, AW'(7 + k), 32'(7 + k));
                push_exp(AW'(7 + k), 32'(7 + k));
            end else begin
                set_req(2, 1'b0, 5'd0, 32'd0);
            end
        end
        step();
        check("b2b_we_c5",    64'(rd_we),    64'd1);
        check("b2b_waddr_c5", 64'(rd_waddr), 64'd10);
        step();
        check("b2b_we_c6",   64'(rd_we),     64'd0);
        check("b2b_busy_c6", 64'(busy_mask), 64'h0);

        // Reset mid-flight
        do_reset();
        set_req(0, 1'b1, 5'd4, 32'h4444_4444);
        set_req(1, 1'b1, 5'd5, 32'h5555_5555);
        set_req(2, 1'b1, 5'd6, 32'h6666_6666);
        push_exp(5'd4, 32'h4444_4444);
        step();
        req_valid = '0;
        check("mid_busy_c1", 64'(busy_mask), 64'h70);
        step();
        check("mid_we_c2",   64'(rd_we),     64'd1);
        check("mid_busy_c2", 64'(busy_mask), 64'h70);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_we_after",    64'(rd_we),     64'd0);
        check("mid_busy_after",  64'(busy_mask), 64'h0);
        check("mid_ready_after", 64'(req_ready), 64'b111);
        repeat (3) begin
            step();
            check("mid_we_quiet", 64'(rd_we), 64'd0);
        end

`ifdef WBARB_STALL_CNT_EN
        // Stall counters, requesters 0 and 1 contending for 10 cycles
        do_reset();
        set_req(0, 1'b1, 5'd11, 32'h0000_B00B);
        set_req(1, 1'b1, 5'd12, 32'h0000_C00C);
        for (int k = 0; k < 11; k++) begin
            if (k % 2 == 0) push_exp(5'd11, 32'h0000_B00B);
            else            push_exp(5'd12, 32'h0000_C00C);
        end
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 4) begin
                check("stall0_c4", 64'(stall_cnt[31:0]),  64'd1);
                check("stall1_c4", 64'(stall_cnt[63:32]), 64'd2);
            end
        end
        step();
        req_valid = '0;
        step();
        step();
        check("stall0_end", 64'(stall_cnt[31:0]),  64'd5);
        check("stall1_end", 64'(stall_cnt[63:32]), 64'd5);
        check("stall2_end", 64'(stall_cnt[95:64]), 64'd0);
`endif

        repeat (4) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
